bias_stream_ctrl: RTL and testbench

//  Parametrised bias source for conv layers. Reads a layer's bias vector from an on-chip ROM
//  and streams it, LANES coefficients per beat, into the layer's bias FIFO (full_n/write).

---
 rtl/bias_stream_ctrl_pkg.sv | 26 ++
 rtl/bias_stream_ctrl_if.sv | 33 +++
 rtl/bias_stream_ctrl_rom.sv | 25 ++
 rtl/bias_stream_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bias_stream_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bias_stream_ctrl_pkg.sv
// Shared constants for the bias/weight streamer family.
// Holds default coefficient sizing, the streamer FSM encoding and small
// elaboration-time helpers used to size address and repeat counters.
package bias_stream_ctrl_pkg;

  // Default sizing for a conv layer bias source.
  localparam int BIAS_COEFF_WIDTH = 16;
  localparam int BIAS_NUM_KERNELS = 16;

  // Streamer control FSM, shared with sibling weight/bias streamers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stream_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/bias_stream_ctrl_if.sv
// Control (start/idle/done) and bias stream (din/full_n/write) bundle.
// master: the streamer drives idle/done/din/write and samples start/full_n.
// slave : the controller/FIFO side, mirror image of master.
interface bias_stream_ctrl_if #(
  parameter int W = 16
);

  logic         ap_start;
  logic         ap_idle;
  logic         ap_done;
  logic [W-1:0] output_V_din;
  logic         output_V_full_n;
  logic         output_V_write;

  modport master (
    input  ap_start,
    input  output_V_full_n,
    output ap_idle,
    output ap_done,
    output output_V_din,
    output output_V_write
  );

  modport slave (
    output ap_start,
    output output_V_full_n,
    input  ap_idle,
    input  ap_done,
    input  output_V_din,
    input  output_V_write
  );

endinterface

// File: rtl/bias_stream_ctrl_rom.sv
// Single-port synchronous ROM holding one layer's packed bias words.
// Latency: 1 cycle (ce/addr sampled at an edge, q valid after that edge).
// Backpressure: none; q holds its last value while ce is low.
// Ports: clk, ce (read enable), addr (word index), q (registered word).
module bias_stream_ctrl_rom
  import bias_stream_ctrl_pkg::*;
#(
  parameter int mem_size   = 16,
  parameter int data_width = 16,
  // Word k lives at init_data[k*data_width +: data_width].
  parameter logic [mem_size*data_width-1:0] init_data = '0
) (
  input  logic                                clk,
  input  logic                                ce,
  input  logic [clog2_min1(mem_size)-1:0]     addr,
  output logic [data_width-1:0]               q
);

  always_ff @(posedge clk) begin
    if (ce) begin
      q <= init_data[addr*data_width +: data_width];
    end
  end

endmodule

// File: rtl/bias_stream_ctrl.sv
// Streams a layer's bias vector from ROM, LANES coefficients per beat, NUM_REPEATS times per start.
// Latency: first beat valid 2 cycles after the start edge, then 1 beat/cycle while full_n is high.
// Backpressure: lossless; a 2-entry skid buffer with read credits absorbs full_n=0 indefinitely.
// Ports: ap_clk, ap_rst (sync, active-high), bus.master = start/idle/done + din/full_n/write.
module bias_stream_ctrl
  import bias_stream_ctrl_pkg::*;
#(
  parameter int NUM_KERNELS = BIAS_NUM_KERNELS,
  parameter int COEFF_WIDTH = BIAS_COEFF_WIDTH,
  parameter int LANES       = 1,
  parameter int NUM_REPEATS = 1,
  // Packed ROM image; pad lanes of the last word are expected to be zero.
  parameter logic [((NUM_KERNELS+LANES-1)/LANES)*LANES*COEFF_WIDTH-1:0] ROM_INIT = '0
) (
  input  logic ap_clk,
  input  logic ap_rst,
  bias_stream_ctrl_if.master bus
);

  localparam int W     = LANES * COEFF_WIDTH;
  localparam int DEPTH = ceil_div(NUM_KERNELS, LANES);
  localparam int AW    = clog2_min1(DEPTH);
  localparam int RW    = clog2_min1(NUM_REPEATS);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(NUM_REPEATS - 1);

  stream_state_t state, state_nxt;

  logic [AW-1:0] addr;
  logic [RW-1:0] rep;
  logic          fetch_end;   // every read of this run has been issued
  logic          in_flight;   // ROM q carries a word that must be pushed this cycle
  logic [W-1:0]  rom_q;

  logic [1:0]    occ;
  logic [W-1:0]  buf0;        // head entry, drives din
  logic [W-1:0]  buf1;

  logic          run;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic          last_pop;
  logic [2:0]    credit_use;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.ap_start) state_nxt = ST_RUN;
      ST_RUN:  if (last_pop)     state_nxt = ST_DONE;
      ST_DONE:                   state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run         = (state == ST_RUN);
    bus.ap_idle = (state != ST_RUN);
    bus.ap_done = (state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Fetch side
  // ---------------------------------------------------------------------------
  assign push = in_flight;
  assign pop  = (occ != 2'd0) && bus.output_V_full_n;

  // Credits: entries held plus the word in flight, minus the entry leaving
  // this cycle. Counting the same-cycle pop is what lets a read issue every
  // cycle under full_n=1; the word it returns lands no earlier than next
  // cycle, when at most one entry can still be occupied.
  assign credit_use = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_en      = run && !fetch_end && (credit_use < 3'd2);

  // Last transfer: nothing left to fetch or land, and the head is the only entry.
  assign last_pop = pop && fetch_end && !in_flight && (occ == 2'd1);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      addr      <= '0;
      rep       <= '0;
      fetch_end <= 1'b0;
      in_flight <= 1'b0;   // any word already read is dropped
    end else begin
      in_flight <= rd_en;
      if (state == ST_IDLE && bus.ap_start) begin
        addr      <= '0;
        rep       <= '0;
        fetch_end <= 1'b0;
      end else if (rd_en) begin
        if (addr == ADDR_LAST) begin
          addr <= '0;
          if (rep == REP_LAST) begin
            rep       <= '0;
            fetch_end <= 1'b1;
          end else begin
            rep <= rep + RW'(1);
          end
        end else begin
          addr <= addr + AW'(1);
        end
      end
    end
  end

  bias_stream_ctrl_rom #(
    .mem_size   (DEPTH),
    .data_width (W),
    .init_data  (ROM_INIT)
  ) u_rom (
    .clk  (ap_clk),
    .ce   (rd_en),
    .addr (addr),
    .q    (rom_q)
  );

  // ---------------------------------------------------------------------------
  // Skid buffer (2 entries, head in buf0)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= rom_q;
          else             buf1 <= rom_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (occ == 2'd1) begin
            buf0 <= rom_q;
          end else begin
            buf0 <= buf1;
            buf1 <= rom_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.output_V_write = (occ != 2'd0);
  assign bus.output_V_din   = buf0;

endmodule

// File: tb/tb_bias_stream_ctrl.sv
module tb_bias_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 4 kernels x 16b, 1 lane, 1 repeat, ROM {1,2,3,4}
  bias_stream_ctrl_if #(.W(16)) ifa ();
  bias_stream_ctrl #(
    .NUM_KERNELS (4),
    .COEFF_WIDTH (16),
    .LANES       (1),
    .NUM_REPEATS (1),
    .ROM_INIT    (64'h0004_0003_0002_0001)
  ) dut_a (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (ifa)
  );

  // DUT B: 5 kernels x 8b, 2 lanes, 3 repeats, ROM {0x0201,0x0403,0x0005}
  bias_stream_ctrl_if #(.W(16)) ifb ();
  bias_stream_ctrl #(
    .NUM_KERNELS (5),
    .COEFF_WIDTH (8),
    .LANES       (2),
    .NUM_REPEATS (3),
    .ROM_INIT    (48'h0005_0403_0201)
  ) dut_b (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: sampled at negedge, i.e. the values the next posedge will act on.
  // ---------------------------------------------------------------------------
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int tx_a = 0, tx_b = 0, done_a = 0, done_b = 0, idle_wr = 0;
  logic        stall_a = 1'b0;
  logic [15:0] stall_din_a = '0;

  always @(negedge clk) begin
    if (stall_a) begin
      chk("din_hold", 32'(ifa.output_V_din), 32'(stall_din_a));
      chk("write_hold", 32'(ifa.output_V_write), 32'd1);
    end
    stall_a     = !rst && ifa.output_V_write && !ifa.output_V_full_n;
    stall_din_a = ifa.output_V_din;
    if (!rst) begin
      if (ifa.output_V_write && ifa.output_V_full_n) begin
        qa.push_back(ifa.output_V_din);
        tx_a++;
      end
      if (ifb.output_V_write && ifb.output_V_full_n) begin
        qb.push_back(ifb.output_V_din);
        tx_b++;
      end
      if (ifa.ap_done) done_a++;
      if (ifb.ap_done) done_b++;
      if (ifa.ap_idle && ifa.output_V_write) idle_wr++;
      if (ifb.ap_idle && ifb.output_V_write) idle_wr++;
    end
  end

  task automatic cmp_seq(input string tag, input logic [15:0] got[$], input logic [15:0] exp[$]);
    chk({tag, "_cnt"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic start_dut(input bit sel);
    if (sel) ifb.ap_start = 1'b1; else ifa.ap_start = 1'b1;
    step();
    ifa.ap_start = 1'b0;
    ifb.ap_start = 1'b0;
  endtask

  // Leaves the bench inside the DONE cycle when done is seen.
  task automatic wait_done(input bit sel, input int budget, input string tag);
    int c = 0;
    while (!(sel ? ifb.ap_done : ifa.ap_done) && c < budget) begin
      step();
      c++;
    end
    chk(tag, 32'(sel ? ifb.ap_done : ifa.ap_done), 32'd1);
  endtask

  // Test 1 per-cycle expectations, index k = cycle after start edge E(k+1).
  int          t1_wr   [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  logic [15:0] t1_din  [8] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
  int          t1_done [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int          t1_idle [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

  logic [15:0] exp_a[$];
  logic [15:0] exp_a2[$];
  logic [15:0] exp_b[$];
  int          d0;
  bit          seen;
  bit          held;

  initial begin
    exp_a  = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_a2 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
    exp_b  = '{16'h0201, 16'h0403, 16'h0005, 16'h0201, 16'h0403, 16'h0005,
               16'h0201, 16'h0403, 16'h0005};

    rst = 1'b1;
    ifa.ap_start = 1'b0; ifa.output_V_full_n = 1'b1;
    ifb.ap_start = 1'b0; ifb.output_V_full_n = 1'b1;
    repeat (2) step();

    // Reset state
    chk("rst_idle_a",  32'(ifa.ap_idle),        32'd1);
    chk("rst_done_a",  32'(ifa.ap_done),        32'd0);
    chk("rst_write_a", 32'(ifa.output_V_write), 32'd0);
    chk("rst_din_a",   32'(ifa.output_V_din),   32'd0);
    chk("rst_idle_b",  32'(ifb.ap_idle),        32'd1);
    chk("rst_write_b", 32'(ifb.output_V_write), 32'd0);
    chk("rst_din_b",   32'(ifb.output_V_din),   32'd0);
    rst = 1'b0;
    step();

    // Test 1: exact cycle timing with full_n=1
    qa.delete();
    start_dut(1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk($sformatf("t1_wr_c%0d", k + 1), 32'(ifa.output_V_write), 32'(t1_wr[k]));
      if (t1_wr[k] != 0)
        chk($sformatf("t1_din_c%0d", k + 1), 32'(ifa.output_V_din), 32'(t1_din[k]));
      chk($sformatf("t1_done_c%0d", k + 1), 32'(ifa.ap_done), 32'(t1_done[k]));
      chk($sformatf("t1_idle_c%0d", k + 1), 32'(ifa.ap_idle), 32'(t1_idle[k]));
    end
    cmp_seq("t1_seq", qa, exp_a);

    // Test 2: multi-lane, padded last word, 3 repeats
    qb.delete();
    d0 = done_b;
    start_dut(1'b1);
    wait_done(1'b1, 60, "t2_done_seen");
    repeat (4) step();
    cmp_seq("t2_seq", qb, exp_b);
    chk("t2_done_cnt", 32'(done_b - d0), 32'd1);

    // Test 3: random back-pressure plus a 20-cycle stall
    qa.delete();
    seen = 1'b0;
    held = 1'b0;
    start_dut(1'b0);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (qa.size() >= 2 && !held) begin
        ifa.output_V_full_n = 1'b0;
        repeat (20) step();
        held = 1'b1;
      end
      ifa.output_V_full_n = 1'($urandom_range(0, 1));
      step();
      if (ifa.ap_done) seen = 1'b1;
    end
    chk("t3_done_seen", 32'(seen), 32'd1);
    ifa.output_V_full_n = 1'b1;
    step();
    cmp_seq("t3_seq", qa, exp_a);

    // Test 4: start in RUN and in DONE ignored; held start re-arms from IDLE
    qa.delete();
    d0 = done_a;
    start_dut(1'b0);
    step();
    step();
    ifa.ap_start = 1'b1;
    step();
    ifa.ap_start = 1'b0;
    wait_done(1'b0, 40, "t4_done1_seen");
    ifa.ap_start = 1'b1;
    step();
    chk("t4_done_ign_idle",  32'(ifa.ap_idle),        32'd1);
    chk("t4_done_ign_done",  32'(ifa.ap_done),        32'd0);
    chk("t4_done_ign_write", 32'(ifa.output_V_write), 32'd0);
    step();
    chk("t4_rearm_idle", 32'(ifa.ap_idle), 32'd0);
    ifa.ap_start = 1'b0;
    wait_done(1'b0, 40, "t4_done2_seen");
    repeat (3) step();
    cmp_seq("t4_seq", qa, exp_a2);
    chk("t4_done_cnt", 32'(done_a - d0), 32'd2);

    // Test 5: reset mid-run while stalled, then a clean replay
    qa.delete();
    start_dut(1'b0);
    repeat (4) step();
    chk("t5_pre_cnt", 32'(qa.size()), 32'd2);
    ifa.output_V_full_n = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("t5_rst_write", 32'(ifa.output_V_write), 32'd0);
    chk("t5_rst_idle",  32'(ifa.ap_idle),        32'd1);
    chk("t5_rst_done",  32'(ifa.ap_done),        32'd0);
    rst = 1'b0;
    ifa.output_V_full_n = 1'b1;
    step();
    qa.delete();
    start_dut(1'b0);
    wait_done(1'b0, 40, "t5_done_seen");
    repeat (3) step();
    cmp_seq("t5_seq", qa, exp_a);

    // Scoreboard totals
    chk("idle_write", 32'(idle_wr), 32'd0);
    chk("tx_a_total", 32'(tx_a), 32'd22);
    chk("tx_b_total", 32'(tx_b), 32'd9);
    chk("done_a_total", 32'(done_a), 32'd5);
    chk("done_b_total", 32'(done_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
